// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0004;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory request/response bus: single outstanding request,
// one-cycle request strobe and one-cycle response strobe.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/next_pc_sel.sv
// Redirect priority mux: exception > jump > branch, targets word aligned.
module next_pc_sel
  import if_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exception,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target
);

  assign redirect = exception | jump | branch_taken;

  // Select the highest-priority redirect target.
  always_comb begin
    target = word_align(branch_target);
    if (exception) begin
      target = word_align(EXC_VECTOR);
    end else if (jump) begin
      target = word_align(jump_target);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, issues single-outstanding fetches to instruction
// memory, buffers one instruction for IF/ID and applies redirects.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | one cycle after reset release, no request outstanding
//   REQ    | request strobe on the bus for exactly one cycle
//   WAIT   | request outstanding; drop=1 means its response is stale
//   FULL   | instruction buffered, waiting for IF/ID to take it
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        exception,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  inst_fetch_unit_if.master imem,
  output logic [31:0] ReadInst,
  output logic [31:0] IF_PC_Plus_4,
  output logic        if_flush,
  output logic        if_hold
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  inst_buf, inst_buf_nx;
  logic         buf_valid, buf_valid_nx;
  logic         drop, drop_nx;
  logic         req_q;
  logic [31:0]  addr_q;
  logic         redirect;
  logic [31:0]  target;
  logic         consume;
  logic [31:0]  pc_plus_4;

  next_pc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redirect      (redirect),
    .target        (target)
  );

  assign pc_plus_4    = pc + 32'd4;
  assign consume      = buf_valid & ~hold & ~redirect;

  assign if_hold      = hold & ~redirect;
  assign if_flush     = redirect | ~buf_valid;
  assign ReadInst     = buf_valid ? inst_buf : NOP_WORD;
  assign IF_PC_Plus_4 = buf_valid ? pc_plus_4 : 32'd0;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // Fetch sequencing; a redirect overrides the PC and empties the buffer.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    inst_buf_nx  = inst_buf;
    buf_valid_nx = buf_valid;
    drop_nx      = drop;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        // The request on the bus now belongs to the old PC stream.
        state_nx = S_WAIT;
        if (redirect) drop_nx = 1'b1;
      end
      S_WAIT: begin
        if (redirect) begin
          if (imem.imem_ack) begin
            drop_nx  = 1'b0;
            state_nx = S_REQ;
          end else begin
            drop_nx  = 1'b1;
          end
        end else if (imem.imem_ack) begin
          if (drop) begin
            drop_nx  = 1'b0;
            state_nx = S_REQ;
          end else begin
            inst_buf_nx  = imem.imem_rdata;
            buf_valid_nx = 1'b1;
            state_nx     = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          state_nx = S_REQ;
        end else if (consume) begin
          pc_nx        = pc_plus_4;
          buf_valid_nx = 1'b0;
          state_nx     = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (redirect) begin
      pc_nx        = target;
      buf_valid_nx = 1'b0;
    end
  end

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst_buf  <= NOP_WORD;
      buf_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      inst_buf  <= inst_buf_nx;
      buf_valid <= buf_valid_nx;
      drop      <= drop_nx;
    end
  end

  // Registered request strobe and address, launched on entry to REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      req_q <= (state_nx == S_REQ);
      if (state_nx == S_REQ) addr_q <= word_align(pc_nx);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a variable-latency memory model
// and scoreboards for fetch addresses and IF/ID hand-offs.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        exception;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ReadInst;
  logic [31:0] IF_PC_Plus_4;
  logic        if_flush;
  logic        if_hold;

  inst_fetch_unit_if bus ();

  inst_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .ReadInst      (ReadInst),
    .IF_PC_Plus_4  (IF_PC_Plus_4),
    .if_flush      (if_flush),
    .if_hold       (if_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  int lat = 1;
  int stale_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2402_0005 : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: answers each request after lat cycles; can inject one stale ack.
  int          stale_done = 0;
  int          cnt = 0;
  bit          pending = 0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    bus.imem_ack = 1'b0;
    if (reset !== 1'b1) begin
      pending = 0;
    end else begin
      if (stale_req != stale_done) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        stale_done     = stale_req;
      end
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(pend_addr);
          pending        = 0;
        end
      end
      if (bus.imem_req === 1'b1) begin
        pending   = 1;
        pend_addr = bus.imem_addr;
        cnt       = lat;
      end
    end
  end

  // Request monitor: every strobe must match the next expected fetch address.
  always @(negedge clk) begin
    if (bus.imem_req === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_req", bus.imem_addr, 32'hFFFF_FFFF);
      end else begin
        check("req_addr", bus.imem_addr, exp_addr_q.pop_front());
      end
    end
  end

  // Hand-off monitor: IF/ID latches whenever the buffer is valid and not held.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset === 1'b1 && if_flush === 1'b0 && hold === 1'b0) begin
      if (exp_inst_q.size() == 0) begin
        check("unexpected_consume", ReadInst, 32'hFFFF_FFFF);
      end else begin
        e = exp_inst_q.pop_front();
        check("consume_inst", ReadInst, e[63:32]);
        check("consume_pc4", IF_PC_Plus_4, e[31:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_full(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (if_flush === 1'b0) got = 1'b1;
    end
    check(tag, {31'b0, got}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; exception = 1'b0; jump = 1'b0;
    branch_taken = 1'b0; jump_target = '0; branch_target = '0;
    repeat (3) next_cycle();

    // Reset state
    @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_inst", ReadInst, 32'h0);
    check("rst_pc4", IF_PC_Plus_4, 32'h0);
    check("rst_flush", {31'b0, if_flush}, 32'd1);
    check("rst_hold", {31'b0, if_hold}, 32'd0);

    // Basic fetch, latency 1
    exp_addr_q.push_back(32'h0);
    exp_inst_q.push_back({32'h2402_0005, 32'h4});
    exp_addr_q.push_back(32'h4);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_req", {31'b0, bus.imem_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("c1_req", {31'b0, bus.imem_req}, 32'd1);
    check("c1_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("c2_flush", {31'b0, if_flush}, 32'd1);
    @(negedge clk);
    check("c3_inst", ReadInst, 32'h2402_0005);
    check("c3_pc4", IF_PC_Plus_4, 32'h4);
    check("c3_flush", {31'b0, if_flush}, 32'd0);

    // Hold while FULL
    next_cycle();
    hold = 1'b1;
    wait_full("hold_fill", 10);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_inst", ReadInst, mem_word(32'h4));
      check("hold_pc4", IF_PC_Plus_4, 32'h8);
      check("hold_if_hold", {31'b0, if_hold}, 32'd1);
    end
    next_cycle();
    hold = 1'b0;
    lat = 3;
    exp_inst_q.push_back({mem_word(32'h4), 32'h8});
    exp_addr_q.push_back(32'h8);

    // Branch during WAIT, latency 3
    next_cycle();
    next_cycle();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    check("br_flush", {31'b0, if_flush}, 32'd1);
    check("br_inst", ReadInst, 32'h0);
    next_cycle();
    branch_taken = 1'b0;
    exp_addr_q.push_back(32'h40);
    exp_inst_q.push_back({mem_word(32'h40), 32'h44});
    exp_addr_q.push_back(32'h44);
    wait_full("br_fill", 20);
    check("br_new_inst", ReadInst, mem_word(32'h40));
    check("br_new_pc4", IF_PC_Plus_4, 32'h44);

    // Simultaneous redirects while a request is on the bus
    next_cycle();
    exception = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    jump_target = 32'h100; branch_target = 32'h200;
    @(negedge clk);
    check("prio_flush", {31'b0, if_flush}, 32'd1);
    next_cycle();
    exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    lat = 1;
    hold = 1'b1;
    exp_addr_q.push_back(32'h8000_0004);
    wait_full("exc_fill", 20);
    check("exc_inst", ReadInst, mem_word(32'h8000_0004));
    check("exc_pc4", IF_PC_Plus_4, 32'h8000_0008);
    check("exc_if_hold", {31'b0, if_hold}, 32'd1);

    // Redirect with hold asserted; unaligned target gets aligned
    next_cycle();
    jump = 1'b1;
    jump_target = 32'h123;
    @(negedge clk);
    check("rh_if_hold", {31'b0, if_hold}, 32'd0);
    check("rh_flush", {31'b0, if_flush}, 32'd1);
    next_cycle();
    jump = 1'b0;
    hold = 1'b0;
    exp_addr_q.push_back(32'h120);
    exp_inst_q.push_back({mem_word(32'h120), 32'h124});
    exp_addr_q.push_back(32'h124);
    wait_full("rh_fill", 20);
    check("rh_pc4", IF_PC_Plus_4, 32'h124);
    lat = 5;

    // Reset mid-WAIT, stale ack after release
    next_cycle();
    next_cycle();
    reset = 1'b0;
    lat = 1;
    @(negedge clk);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    check("mid_rst_flush", {31'b0, if_flush}, 32'd1);
    check("mid_rst_inst", ReadInst, 32'h0);
    next_cycle();
    reset = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_inst_q.push_back({32'h2402_0005, 32'h4});
    exp_addr_q.push_back(32'h4);
    next_cycle();
    stale_req++;
    wait_full("stale_fill", 20);
    check("stale_inst", ReadInst, 32'h2402_0005);

    // PC wrap at the top of the address space
    next_cycle();
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    next_cycle();
    jump = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_inst_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
    exp_addr_q.push_back(32'h0);
    wait_full("wrap_fill", 20);
    check("wrap_pc4", IF_PC_Plus_4, 32'h0);
    next_cycle();
    hold = 1'b1;
    repeat (6) @(negedge clk);
    check("wrap_held_inst", ReadInst, 32'h2402_0005);

    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
